// File: rtl/xform_link_sequencer.sv
// Walks the xgen banks one link at a time, captures each 15-word xform and streams it out.
// Define XFORM_SEQ_REVERSE_EN for backward-pass order (NUM_LINKS down to 1).
module xform_link_sequencer #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DECIMAL_BITS = 16,
  parameter int unsigned NUM_LINKS    = 7,
  parameter int unsigned LINK_W       = 3,
  parameter int unsigned XGEN_LAT     = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  input  logic                trig_valid,
  output logic                trig_ready,
  input  logic [WIDTH-1:0]    sinq_in,
  input  logic [WIDTH-1:0]    cosq_in,
  output logic [LINK_W-1:0]   link_sel,
  output logic [WIDTH-1:0]    sinq_out,
  output logic [WIDTH-1:0]    cosq_out,
  input  logic [15*WIDTH-1:0] xform_in,
  output logic [15*WIDTH-1:0] xform_out,
  output logic [LINK_W-1:0]   xform_link,
  output logic                xform_valid,
  input  logic                xform_ready
);

  localparam int unsigned CNT_W = (XGEN_LAT > 1) ? $clog2(XGEN_LAT) : 1;

`ifdef XFORM_SEQ_REVERSE_EN
  localparam logic [LINK_W-1:0] FirstLink = LINK_W'(NUM_LINKS);
  localparam logic [LINK_W-1:0] LastLink  = LINK_W'(1);
`else
  localparam logic [LINK_W-1:0] FirstLink = LINK_W'(1);
  localparam logic [LINK_W-1:0] LastLink  = LINK_W'(NUM_LINKS);
`endif

  if (XGEN_LAT < 1) begin : g_bad_lat
    $error("XGEN_LAT must be at least 1");
  end
  if ((1 << LINK_W) <= NUM_LINKS) begin : g_bad_link_w
    $error("LINK_W too narrow for NUM_LINKS");
  end
  if (DECIMAL_BITS >= WIDTH) begin : g_bad_frac
    $error("DECIMAL_BITS must be below WIDTH");
  end

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StEmit, StFin} state_e;

  state_e               state_q, state_d;
  logic [LINK_W-1:0]    link_q, link_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     sin_q, sin_d, cos_q, cos_d;
  logic [15*WIDTH-1:0]  xf_q, xf_d;
  logic [LINK_W-1:0]    xlink_q, xlink_d;
  logic [LINK_W-1:0]    sel_q, sel_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      link_q  <= '0;
      cnt_q   <= '0;
      sin_q   <= '0;
      cos_q   <= '0;
      xf_q    <= '0;
      xlink_q <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      link_q  <= link_d;
      cnt_q   <= cnt_d;
      sin_q   <= sin_d;
      cos_q   <= cos_d;
      xf_q    <= xf_d;
      xlink_q <= xlink_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    link_d  = link_q;
    cnt_d   = cnt_q;
    sin_d   = sin_q;
    cos_d   = cos_q;
    xf_d    = xf_q;
    xlink_d = xlink_q;
    sel_d   = sel_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StIssue;
          link_d  = FirstLink;
        end
      end
      StIssue: begin
        if (trig_valid) begin
          sin_d   = sinq_in;
          cos_d   = cosq_in;
          sel_d   = link_q;
          cnt_d   = CNT_W'(XGEN_LAT - 1);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          xf_d    = xform_in;
          xlink_d = link_q;
          state_d = StEmit;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StEmit: begin
        if (xform_ready) begin
          if (link_q == LastLink) begin
            state_d = StFin;
            sel_d   = '0;
          end else begin
`ifdef XFORM_SEQ_REVERSE_EN
            link_d  = link_q - 1'b1;
`else
            link_d  = link_q + 1'b1;
`endif
            state_d = StIssue;
          end
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Status outputs decode straight from state so reset clears them asynchronously.
  assign busy        = (state_q == StIssue) || (state_q == StWait) || (state_q == StEmit);
  assign done        = (state_q == StFin);
  assign trig_ready  = (state_q == StIssue);
  assign xform_valid = (state_q == StEmit);
  assign link_sel    = sel_q;
  assign sinq_out    = sin_q;
  assign cosq_out    = cos_q;
  assign xform_out   = xf_q;
  assign xform_link  = xlink_q;

endmodule

// File: tb/tb_xform_link_sequencer.sv
// Directed bench for xform_link_sequencer with a combinational stand-in for the xgen mux.
module tb_xform_link_sequencer;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy, done;
  logic          trig_valid, trig_ready;
  logic [W-1:0]  sinq_in, cosq_in, sinq_out, cosq_out;
  logic [2:0]    link_sel, xform_link;
  logic [15*W-1:0] xform_in, xform_out;
  logic          xform_valid, xform_ready;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int out_cnt  = 0;

  always #5 clk = ~clk;

  xform_link_sequencer #(
    .WIDTH(32), .DECIMAL_BITS(16), .NUM_LINKS(7), .LINK_W(3), .XGEN_LAT(1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .trig_valid(trig_valid), .trig_ready(trig_ready),
    .sinq_in(sinq_in), .cosq_in(cosq_in), .link_sel(link_sel),
    .sinq_out(sinq_out), .cosq_out(cosq_out), .xform_in(xform_in),
    .xform_out(xform_out), .xform_link(xform_link),
    .xform_valid(xform_valid), .xform_ready(xform_ready)
  );

  // Stand-in xgen: word0 = -cos, other words mix sin, cos, word index and bank.
  function automatic logic [15*W-1:0] xgen(input logic [2:0] l, input logic [W-1:0] s,
                                           input logic [W-1:0] c);
    logic [15*W-1:0] r;
    r = '0;
    if (l != 3'd0) begin
      r[W-1:0] = -c;
      for (int i = 1; i < 15; i++) r[i*W +: W] = s ^ (c + W'(i) * 32'h0101) ^ {l, 29'b0};
    end
    return r;
  endfunction

  always_comb xform_in = xgen(link_sel, sinq_out, cosq_out);

  always @(posedge clk) begin
    if (done) done_cnt++;
    if (xform_valid && xform_ready) out_cnt++;
  end

  task automatic check(input string name, input logic [15*W-1:0] act,
                       input logic [15*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] sinq;
    logic [W-1:0] cosq;
    int           stall;
    logic [2:0]   link_fwd;
    logic [2:0]   link_rev;
  } vec_t;

  vec_t vec[7];

  function automatic logic [2:0] exp_link(input int k);
`ifdef XFORM_SEQ_REVERSE_EN
    return vec[k].link_rev;
`else
    return vec[k].link_fwd;
`endif
  endfunction

  task automatic start_trav();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_trig_ready", trig_ready, 1);
  endtask

  // One link: trig handshake, latency check, optional stall, xform handshake.
  task automatic do_link(input int k, input int stall, input bit pulse_start);
    logic [2:0] l;
    logic [15*W-1:0] exp_x;
    int t;
    l = exp_link(k);
    t = 0;
    while (!trig_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("trig_ready_wait", trig_ready, 1);
    sinq_in    = vec[k].sinq;
    cosq_in    = vec[k].cosq;
    trig_valid = 1'b1;
    @(negedge clk);
    trig_valid = 1'b0;
    start      = pulse_start;
    check("wait_no_valid", xform_valid, 0);
    check("wait_trig_ready", trig_ready, 0);
    check("wait_link_sel", link_sel, l);
    check("wait_sinq_out", sinq_out, vec[k].sinq);
    check("wait_cosq_out", cosq_out, vec[k].cosq);
    @(negedge clk);
    start = 1'b0;
    exp_x = xgen(l, vec[k].sinq, vec[k].cosq);
    check("emit_valid_lat2", xform_valid, 1);
    check("emit_link", xform_link, l);
    check("emit_xform", xform_out, exp_x);
    for (int i = 0; i < stall; i++) begin
      xform_ready = 1'b0;
      trig_valid  = 1'b1;
      sinq_in     = 32'hDEAD_BEEF;
      @(negedge clk);
      check("stall_valid", xform_valid, 1);
      check("stall_xform", xform_out, exp_x);
      check("stall_link", xform_link, l);
      check("stall_trig_ready", trig_ready, 0);
      check("stall_sinq_hold", sinq_out, vec[k].sinq);
    end
    trig_valid  = 1'b0;
    xform_ready = 1'b1;
    @(negedge clk);
    if (k == 6) begin
      start = 1'b1;
      check("fin_done", done, 1);
      check("fin_busy", busy, 0);
      check("fin_link_sel", link_sel, 0);
      @(negedge clk);
      start = 1'b0;
      check("after_fin_done", done, 0);
      check("after_fin_idle", busy, 0);
    end else begin
      check("next_issue", trig_ready, 1);
    end
  endtask

  initial begin
    vec[0] = '{32'h0000_1000, 32'h0000_FF00, 0, 3'd1, 3'd7};
    vec[1] = '{32'h0000_8000, 32'h0000_DDB4, 10, 3'd2, 3'd6};
    vec[2] = '{32'hFFFF_4000, 32'h0000_B505, 0, 3'd3, 3'd5};
    vec[3] = '{32'h0001_0000, 32'h0000_0000, 0, 3'd4, 3'd4};
    vec[4] = '{32'h1234_5678, 32'h8765_4321, 0, 3'd5, 3'd3};
    vec[5] = '{32'hFFFF_0000, 32'h0000_0001, 0, 3'd6, 3'd2};
    vec[6] = '{32'h0000_0000, 32'h0001_0000, 0, 3'd7, 3'd1};

    reset = 1'b1; start = 1'b0; trig_valid = 1'b0; xform_ready = 1'b1;
    sinq_in = '0; cosq_in = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_trig_ready", trig_ready, 0);
    check("rst_xform_out", xform_out, 0);
    reset = 1'b0;
    trig_valid = 1'b1;
    @(negedge clk);
    trig_valid = 1'b0;
    check("idle_ignores_trig", sinq_out, 0);
    check("idle_link_sel", link_sel, 0);

    // Back-to-back traversal, ready always high.
    start_trav();
    for (int k = 0; k < 7; k++) do_link(k, 0, 1'b0);
    check("travA_outputs", out_cnt, 7);
    check("travA_done", done_cnt, 1);

    // Sin=0, cos=1.0 on the 7th issue (link 7 forward): word0 must come back as -65536.
    check("ax_ax_word", xform_out[W-1:0], 32'hFFFF_0000);

    // Stall on second link, start pulses mid-traversal and in FIN.
    start_trav();
    for (int k = 0; k < 7; k++) do_link(k, vec[k].stall, k == 3);
    check("travB_outputs", out_cnt, 14);
    check("travB_done", done_cnt, 2);

    // Reset while the third link is in WAIT.
    start_trav();
    do_link(0, 0, 1'b0);
    do_link(1, 0, 1'b0);
    sinq_in = vec[2].sinq; cosq_in = vec[2].cosq; trig_valid = 1'b1;
    @(negedge clk);
    trig_valid = 1'b0;
    check("pre_rst_link_sel", link_sel, exp_link(2));
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_valid", xform_valid, 0);
    check("midrst_link_sel", link_sel, 0);
    check("midrst_sinq", sinq_out, 0);
    check("midrst_xlink", xform_link, 0);
    check("midrst_xform", xform_out, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_no_done", done_cnt, 2);
    start_trav();
    do_link(0, 0, 1'b0);
    check("restart_first_link", xform_link, exp_link(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
